// File: rtl/bbus_pkg.sv
// B-bus select code map and default datapath sizing.
// Shared by every block that drives or decodes B_SEL.
package bbus_pkg;

    localparam int DW_DEF   = 19;
    localparam int NREG_DEF = 12;

    localparam int SEL_NONE   = 0;
    localparam int SEL_DMAR   = 1;
    localparam int SEL_DMDR   = 2;
    localparam int SEL_R_BASE = 3;

    function automatic int sel_imm(input int nreg);
        return nreg + SEL_R_BASE;
    endfunction

endpackage

// File: rtl/bbus_regbank.sv
// General register bank: one write port, one B-bus read port.
// The read port forwards same-cycle write data.
module bbus_regbank
    import bbus_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int NREG = NREG_DEF,
    parameter int SELW = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic [SELW-1:0] wr_addr,
    input  logic [DW-1:0]   wr_data,
    input  logic [SELW-1:0] rd_idx,
    output logic [DW-1:0]   rd_data
);

    localparam int IW = $clog2(NREG);
    localparam logic [SELW-1:0] NR = SELW'(NREG);

    logic [DW-1:0] regs [NREG];
    logic          wr_ok;
    logic          rd_ok;
    logic [IW-1:0] wi;
    logic [IW-1:0] ri;

    assign wr_ok = wr_en && (wr_addr < NR);
    assign rd_ok = rd_idx < NR;
    assign wi    = wr_addr[IW-1:0];
    assign ri    = rd_idx[IW-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            regs[wi] <= wr_data;
        end
    end

    always_comb begin
        rd_data = '0;
        if (rd_ok) begin
            rd_data = (wr_ok && wr_addr == rd_idx) ? wr_data : regs[ri];
        end
    end

endmodule

// File: rtl/bbus_rf.sv
// B-bus operand source: register bank, select decode and a
// one-deep valid/ready output register.
module bbus_rf
    import bbus_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int NREG = NREG_DEF,
    parameter int SELW = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SELW-1:0] B_SEL,
    input  logic            sel_valid,
    output logic            sel_ready,
    input  logic [DW-1:0]   DMAR,
    input  logic [DW-1:0]   DMDR,
    input  logic [DW-1:0]   IMM,
    input  logic            wr_en,
    input  logic [SELW-1:0] WR_ADDR,
    input  logic [DW-1:0]   wr_data,
    input  logic            b_ready,
    output logic [DW-1:0]   b_out,
    output logic            b_valid,
    output logic            b_err
);

    localparam logic [SELW-1:0] C_NONE = SELW'(SEL_NONE);
    localparam logic [SELW-1:0] C_DMAR = SELW'(SEL_DMAR);
    localparam logic [SELW-1:0] C_DMDR = SELW'(SEL_DMDR);
    localparam logic [SELW-1:0] C_RB   = SELW'(SEL_R_BASE);
    localparam logic [SELW-1:0] C_IMM  = SELW'(sel_imm(NREG));

    logic [SELW-1:0] ridx;
    logic [DW-1:0]   rdat;
    logic [DW-1:0]   op;
    logic            err;
    logic            acc;

    assign ridx = B_SEL - C_RB;

    bbus_regbank #(
        .DW   (DW),
        .NREG (NREG),
        .SELW (SELW)
    ) u_rb (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (WR_ADDR),
        .wr_data (wr_data),
        .rd_idx  (ridx),
        .rd_data (rdat)
    );

    always_comb begin
        op  = '0;
        err = 1'b0;
        unique case (1'b1)
            (B_SEL == C_NONE): op = '0;
            (B_SEL == C_DMAR): op = DMAR;
            (B_SEL == C_DMDR): op = DMDR;
            (B_SEL >= C_RB && B_SEL < C_IMM): op = rdat;
            (B_SEL == C_IMM): op = IMM;
            default: err = 1'b1;
        endcase
    end

    assign sel_ready = !b_valid || b_ready;
    assign acc       = sel_valid && sel_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_out   <= '0;
            b_valid <= 1'b0;
            b_err   <= 1'b0;
        end else if (acc) begin
            b_out   <= op;
            b_err   <= err;
            b_valid <= 1'b1;
        end else if (b_ready) begin
            b_valid <= 1'b0;
        end
    end

endmodule
